// File: rtl/alu_seq_if.sv
// Handshake bus between the operand issuer (master) and alu_seq (slave).
// Both directions use valid/ready; result flags travel alongside o.
interface alu_seq_if #(
  parameter int unsigned W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   opr;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] o;
  logic         zero;
  logic         carry;
  logic         ovf;
  logic         neg;

  modport master (
    output in_valid, opr, a, b, out_ready,
    input  in_ready, out_valid, o, zero, carry, ovf, neg
  );

  modport slave (
    input  in_valid, opr, a, b, out_ready,
    output in_ready, out_valid, o, zero, carry, ovf, neg
  );
endinterface

// File: rtl/alu_seq.sv
// Registered W-bit ALU with valid/ready handshakes, status flags and an
// iterative shift-add multiplier on opcode 10.
module alu_seq #(
  parameter int unsigned W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int unsigned CW      = (W > 2) ? $clog2(W) : 1;
  localparam logic [3:0]  OP_MUL  = 4'd10;
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    o_q, o_d;
  logic            zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, neg_q, neg_d;
  logic [2*W-1:0]  mcand_q, mcand_d, prod_q, prod_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept;
  logic [W:0]      sum, diff;
  logic [W-1:0]    alu_o;
  logic            alu_c, alu_v;
  logic [2*W-1:0]  prod_acc;

  assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.o         = o_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.neg       = neg_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign prod_acc = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle datapath: result plus carry/overflow for every non-MUL opcode
  always_comb begin
    sum   = {1'b0, bus.a} + {1'b0, bus.b};
    diff  = {1'b0, bus.a} - {1'b0, bus.b};
    alu_o = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.opr)
      4'd0: begin
        alu_o = sum[W-1:0];
        alu_c = sum[W];
        alu_v = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
      end
      4'd1: begin
        alu_o = diff[W-1:0];
        alu_c = diff[W];
        alu_v = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
      end
      4'd2:  alu_o = bus.a & bus.b;
      4'd3:  alu_o = bus.a | bus.b;
      4'd4:  alu_o = bus.a ^ bus.b;
      4'd5:  alu_o = ~bus.a;
      4'd6: begin
        alu_o = {bus.a[W-2:0], 1'b0};
        alu_c = bus.a[W-1];
      end
      4'd7: begin
        alu_o = {1'b0, bus.a[W-1:1]};
        alu_c = bus.a[0];
      end
      4'd8: begin
        alu_o = bus.a + W'(1);
        alu_c = &bus.a;
        alu_v = (bus.a == MAX_POS);
      end
      4'd9: begin
        alu_o = bus.a - W'(1);
        alu_c = (bus.a == '0);
        alu_v = (bus.a == MIN_NEG);
      end
      4'd11: alu_o = {bus.a[W-2:0], bus.a[W-1]};
      4'd12: alu_o = ~(bus.a & bus.b);
      4'd13: alu_o = ~(bus.a | bus.b);
      4'd14: alu_o = W'(bus.a == bus.b);
      4'd15: alu_o = W'(bus.a < bus.b);
      default: alu_o = '0;
    endcase
  end

  // Next-state: accept/issue, MUL iteration and result registration
  always_comb begin
    state_d  = state_q;
    o_d      = o_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (bus.opr == OP_MUL) begin
            state_d  = S_BUSY;
            mcand_d  = {{W{1'b0}}, bus.a};
            mplier_d = bus.b;
            prod_d   = '0;
            cnt_d    = '0;
          end else begin
            state_d = S_DONE;
            o_d     = alu_o;
            carry_d = alu_c;
            ovf_d   = alu_v;
            zero_d  = (alu_o == '0);
            neg_d   = alu_o[W-1];
          end
        end else if ((state_q == S_DONE) && bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        prod_d   = prod_acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) begin
          state_d = S_DONE;
          o_d     = prod_acc[W-1:0];
          carry_d = |prod_acc[2*W-1:W];
          ovf_d   = 1'b0;
          zero_d  = (prod_acc[W-1:0] == '0);
          neg_d   = prod_acc[W-1];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      o_q      <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      o_q      <= o_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded bench for alu_seq: W=4 and W=8 instances, results checked
// against an integer reference model on every output transfer.
module tb_alu_seq;

  typedef struct packed {
    logic [7:0] o;
    logic       z;
    logic       c;
    logic       v;
    logic       n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   fails = 0;
  exp_t sb4[$];
  exp_t sb8[$];

  alu_seq_if #(.W(4)) bus4 ();
  alu_seq_if #(.W(8)) bus8 ();

  alu_seq #(.W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  alu_seq #(.W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  always #5 clk = ~clk;

  function automatic exp_t model(int w, int op, int a, int b);
    exp_t e;
    int mask = (1 << w) - 1;
    int hi   = 1 << (w - 1);
    int sa   = (a >= hi) ? a - (1 << w) : a;
    int sbv  = (b >= hi) ? b - (1 << w) : b;
    int r = 0;
    int s;
    longint p;
    e = '0;
    case (op)
      0: begin r = a + b; e.c = (r > mask); s = sa + sbv; e.v = (s > hi - 1) || (s < -hi); end
      1: begin r = a - b; e.c = (a < b);    s = sa - sbv; e.v = (s > hi - 1) || (s < -hi); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: begin r = a * 2; e.c = ((a >> (w - 1)) & 1) == 1; end
      7: begin r = a / 2; e.c = (a & 1) == 1; end
      8: begin r = a + 1; e.c = (a == mask); e.v = (a == hi - 1); end
      9: begin r = a - 1; e.c = (a == 0);    e.v = (a == hi); end
      10: begin p = longint'(a) * longint'(b); r = int'(p & longint'(mask)); e.c = (p >> w) != 0; end
      11: r = (a << 1) | (a >> (w - 1));
      12: r = ~(a & b);
      13: r = ~(a | b);
      14: r = (a == b) ? 1 : 0;
      default: r = (a < b) ? 1 : 0;
    endcase
    r   = r & mask;
    e.o = 8'(r);
    e.z = (r == 0);
    e.n = ((r >> (w - 1)) & 1) == 1;
    return e;
  endfunction

  // Scoreboard: pop on output transfer, push on input accept (next edge)
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus4.out_valid && bus4.out_ready) begin
        tests_run++;
        if (sb4.size() == 0) begin
          fails++;
          $display("FAIL sb4_unexpected: got o=%h with no pending expectation", bus4.o);
        end else begin
          e = sb4.pop_front();
          if ({bus4.o, bus4.zero, bus4.carry, bus4.ovf, bus4.neg} !== {e.o[3:0], e.z, e.c, e.v, e.n}) begin
            fails++;
            $display("FAIL sb4_result: got o=%h z%b c%b v%b n%b expected o=%h z%b c%b v%b n%b",
                     bus4.o, bus4.zero, bus4.carry, bus4.ovf, bus4.neg, e.o[3:0], e.z, e.c, e.v, e.n);
          end
        end
      end
      if (bus4.in_valid && bus4.in_ready)
        sb4.push_back(model(4, int'(bus4.opr), int'(bus4.a), int'(bus4.b)));
      if (bus8.out_valid && bus8.out_ready) begin
        tests_run++;
        if (sb8.size() == 0) begin
          fails++;
          $display("FAIL sb8_unexpected: got o=%h with no pending expectation", bus8.o);
        end else begin
          e = sb8.pop_front();
          if ({bus8.o, bus8.zero, bus8.carry, bus8.ovf, bus8.neg} !== {e.o, e.z, e.c, e.v, e.n}) begin
            fails++;
            $display("FAIL sb8_result: got o=%h z%b c%b v%b n%b expected o=%h z%b c%b v%b n%b",
                     bus8.o, bus8.zero, bus8.carry, bus8.ovf, bus8.neg, e.o, e.z, e.c, e.v, e.n);
          end
        end
      end
      if (bus8.in_valid && bus8.in_ready)
        sb8.push_back(model(8, int'(bus8.opr), int'(bus8.a), int'(bus8.b)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    bus4.in_valid = v;
    bus4.opr      = op;
    bus4.a        = a;
    bus4.b        = b;
  endtask

  task automatic test_reset();
    drive4(1'b0, 4'd0, 4'd0, 4'd0);
    bus4.out_ready = 1'b1;
    bus8.in_valid  = 1'b0;
    bus8.opr       = 4'd0;
    bus8.a         = 8'd0;
    bus8.b         = 8'd0;
    bus8.out_ready = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    tests_run++;
    if ({bus4.out_valid, bus4.o, bus4.zero, bus4.carry, bus4.ovf, bus4.neg} !== 9'b0) begin
      fails++;
      $display("FAIL reset_state4: got v%b o=%h flags=%b%b%b%b expected all zero",
               bus4.out_valid, bus4.o, bus4.zero, bus4.carry, bus4.ovf, bus4.neg);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus4.in_ready !== 1'b1 || bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: got rdy4=%b rdy8=%b vld8=%b expected 1 1 0",
               bus4.in_ready, bus8.in_ready, bus8.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int ops[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 12, 13};
    bus4.out_ready = 1'b1;
    foreach (ops[i]) begin
      drive4(1'b1, 4'(ops[i]), 4'd7, 4'd3);
      step();
      tests_run++;
      if (bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_throughput op%0d: got vld=%b rdy=%b expected 1 1", ops[i], bus4.out_valid, bus4.in_ready);
      end
      if (ops[i] == 0) begin
        tests_run++;
        if ({bus4.o, bus4.neg, bus4.ovf, bus4.carry} !== {4'hA, 1'b1, 1'b1, 1'b0}) begin
          fails++;
          $display("FAIL b2b_add: got o=%h n%b v%b c%b expected o=a n1 v1 c0", bus4.o, bus4.neg, bus4.ovf, bus4.carry);
        end
      end else if (ops[i] == 1) begin
        tests_run++;
        if ({bus4.o, bus4.carry} !== {4'h4, 1'b0}) begin
          fails++;
          $display("FAIL b2b_sub: got o=%h c%b expected o=4 c0", bus4.o, bus4.carry);
        end
      end else if (ops[i] == 6 || ops[i] == 9) begin
        tests_run++;
        if (bus4.o !== ((ops[i] == 6) ? 4'hE : 4'h6)) begin
          fails++;
          $display("FAIL b2b_shl_dec op%0d: got o=%h expected %h", ops[i], bus4.o, (ops[i] == 6) ? 4'hE : 4'h6);
        end
      end
    end
    drive4(1'b0, 4'd0, 4'd0, 4'd0);
    step();
    tests_run++;
    if (bus4.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: got out_valid=%b expected 0", bus4.out_valid);
    end
  endtask

  task automatic test_corners();
    drive4(1'b1, 4'd1, 4'd2, 4'd3);
    step();
    tests_run++;
    if ({bus4.o, bus4.carry, bus4.neg} !== {4'hF, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL sub_borrow: got o=%h c%b n%b expected o=f c1 n1", bus4.o, bus4.carry, bus4.neg);
    end
    drive4(1'b1, 4'd14, 4'd5, 4'd5);
    step();
    tests_run++;
    if (bus4.o !== 4'h1) begin
      fails++;
      $display("FAIL eq: got o=%h expected 1", bus4.o);
    end
    drive4(1'b1, 4'd15, 4'd2, 4'd3);
    step();
    tests_run++;
    if (bus4.o !== 4'h1) begin
      fails++;
      $display("FAIL lt: got o=%h expected 1", bus4.o);
    end
    drive4(1'b1, 4'd8, 4'hF, 4'd0);
    step();
    tests_run++;
    if ({bus4.o, bus4.zero, bus4.carry} !== {4'h0, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL inc_wrap: got o=%h z%b c%b expected o=0 z1 c1", bus4.o, bus4.zero, bus4.carry);
    end
    drive4(1'b0, 4'd0, 4'd0, 4'd0);
    step();
  endtask

  task automatic test_mul();
    logic [3:0] ma[2] = '{4'd7, 4'd3};
    logic [3:0] mb[2] = '{4'd3, 4'd5};
    logic [4:0] want[2] = '{{4'h5, 1'b1}, {4'hF, 1'b0}};
    for (int k = 0; k < 2; k++) begin
      drive4(1'b1, 4'd10, ma[k], mb[k]);
      step();
      drive4(1'b0, 4'd0, 4'd0, 4'd0);
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (bus4.in_ready !== 1'b0 || bus4.out_valid !== 1'b0) begin
          fails++;
          $display("FAIL mul_busy k%0d cyc%0d: got rdy=%b vld=%b expected 0 0", k, i, bus4.in_ready, bus4.out_valid);
        end
        step();
      end
      tests_run++;
      if ({bus4.out_valid, bus4.o, bus4.carry} !== {1'b1, want[k]}) begin
        fails++;
        $display("FAIL mul_result k%0d: got vld=%b o=%h c%b expected vld=1 o=%h c%b",
                 k, bus4.out_valid, bus4.o, bus4.carry, want[k][4:1], want[k][0]);
      end
    end
    step();
  endtask

  task automatic test_backpressure();
    bus4.out_ready = 1'b0;
    drive4(1'b1, 4'd0, 4'd3, 4'd4);
    step();
    drive4(1'b1, 4'd1, 4'd9, 4'd2);
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if ({bus4.out_valid, bus4.in_ready, bus4.o, bus4.zero, bus4.carry, bus4.ovf, bus4.neg} !== {1'b1, 1'b0, 4'h7, 4'b0000}) begin
        fails++;
        $display("FAIL bp_hold cyc%0d: got vld=%b rdy=%b o=%h flags=%b%b%b%b expected vld=1 rdy=0 o=7 flags=0000",
                 i, bus4.out_valid, bus4.in_ready, bus4.o, bus4.zero, bus4.carry, bus4.ovf, bus4.neg);
      end
      step();
    end
    bus4.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus4.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: got %b expected 1", bus4.in_ready);
    end
    step();
    drive4(1'b0, 4'd0, 4'd0, 4'd0);
    tests_run++;
    if ({bus4.out_valid, bus4.o} !== {1'b1, 4'h7}) begin
      fails++;
      $display("FAIL bp_next: got vld=%b o=%h expected vld=1 o=7", bus4.out_valid, bus4.o);
    end
    step();
  endtask

  task automatic test_reset_mid_mul();
    drive4(1'b1, 4'd10, 4'd7, 4'd3);
    step();
    drive4(1'b0, 4'd0, 4'd0, 4'd0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus4.out_valid, bus4.o, bus4.zero, bus4.carry, bus4.ovf, bus4.neg} !== 9'b0) begin
      fails++;
      $display("FAIL mid_mul_reset: got vld=%b o=%h flags=%b%b%b%b expected all zero",
               bus4.out_valid, bus4.o, bus4.zero, bus4.carry, bus4.ovf, bus4.neg);
    end
    sb4.delete();
    sb8.delete();
    step();
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_ready: got rdy=%b vld=%b expected 1 0", bus4.in_ready, bus4.out_valid);
    end
    drive4(1'b1, 4'd0, 4'd1, 4'd1);
    step();
    drive4(1'b0, 4'd0, 4'd0, 4'd0);
    tests_run++;
    if (bus4.o !== 4'h2) begin
      fails++;
      $display("FAIL post_reset_add: got o=%h expected 2", bus4.o);
    end
    step();
  endtask

  task automatic test_w8();
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.opr       = 4'd10;
    bus8.a         = 8'h10;
    bus8.b         = 8'h10;
    step();
    bus8.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b0) begin
        fails++;
        $display("FAIL w8_mul_busy cyc%0d: got vld=%b rdy=%b expected 0 0", i, bus8.out_valid, bus8.in_ready);
      end
      step();
    end
    tests_run++;
    if ({bus8.out_valid, bus8.o, bus8.zero, bus8.carry} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL w8_mul: got vld=%b o=%h z%b c%b expected vld=1 o=00 z1 c1",
               bus8.out_valid, bus8.o, bus8.zero, bus8.carry);
    end
    bus8.in_valid = 1'b1;
    bus8.opr      = 4'd0;
    bus8.a        = 8'h7F;
    bus8.b        = 8'h01;
    step();
    bus8.in_valid = 1'b0;
    tests_run++;
    if ({bus8.o, bus8.ovf, bus8.neg} !== {8'h80, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL w8_add: got o=%h v%b n%b expected o=80 v1 n1", bus8.o, bus8.ovf, bus8.neg);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_corners();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_w8();
    step();
    tests_run++;
    if (sb4.size() != 0 || sb8.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d/%0d pending expected 0/0", sb4.size(), sb8.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the team's 4-bit combinational ALU. It keeps the same 16-opcode space, widened to W bits. It adds valid/ready handshakes on input and output, a registered result with status flags, and an iterative multi-cycle multiplier on opcode 10. It sits between an operand/opcode issuer and a result consumer that may apply backpressure.

Parameters:
W, 4, operand and result width in bits (W >= 2)

Ports:
clk  input  1  rising-edge clock; sole clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  opr/a/b valid this cycle
in_ready  output  1  block accepts an operation this cycle
opr  input  4  opcode
a  input  W  operand A
b  input  W  operand B
out_valid  output  1  o and flags hold a valid result
out_ready  input  1  consumer takes the result this cycle
o  output  W  registered result
zero  output  1  o == 0
carry  output  1  carry/borrow/shift-out, per opcode
ovf  output  1  signed overflow (ADD/SUB/INC/DEC only)
neg  output  1  o[W-1]

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0; o=0; zero=0, carry=0, ovf=0, neg=0; any in-progress MUL is abandoned. After reset release, in_ready=1.
- Accept: a transfer occurs on a rising edge where in_valid && in_ready; opr/a/b are sampled at that edge only. Later changes on the inputs are ignored.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: MUL iterating; in_ready=0, out_valid=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Transitions:
  - IDLE/DONE accepting a single-cycle op -> DONE, result registered at the same edge (1-cycle latency).
  - IDLE/DONE accepting MUL -> BUSY.
  - BUSY -> DONE after exactly W iterations.
  - DONE with out_ready and no accept -> IDLE.
  - DONE with out_ready and accept -> stays DONE with the new result, giving 1 op/cycle throughput.
  - DONE with out_ready=0: o and flags held stable; in_ready=0.
- Opcodes (all arithmetic mod 2^W, unsigned unless noted; carry=0 and ovf=0 unless listed):
  - 0 ADD a+b: carry=carry-out; ovf=signed overflow.
  - 1 SUB a-b: carry=borrow (a<b unsigned); ovf=signed overflow.
  - 2 AND, 3 OR, 4 XOR.
  - 5 NOT a.
  - 6 SHL a by 1: carry=a[W-1].
  - 7 SHR a by 1 (logical): carry=a[0].
  - 8 INC a: carry when a is all-ones; ovf when a=0111..1.
  - 9 DEC a: carry when a=0; ovf when a=1000..0.
  - 10 MUL: shift-add, one bit of b per cycle, LSB first. o=low W bits of a*b; carry=1 iff the high W bits are nonzero.
  - 11 ROL a by 1.
  - 12 NAND, 13 NOR.
  - 14 EQ: o=1 if a==b else 0.
  - 15 LT: o=1 if a<b (unsigned) else 0.
- Flags: zero and neg derive from the final o for every opcode, MUL included.
- MUL latency: out_valid rises W+1 edges after the accept edge, i.e. the accept edge plus W BUSY cycles. b=0 or a=0 still takes the full W cycles.
- MUL internals: the partial product register is 2W bits wide. o and the flags are not updated until BUSY->DONE; during BUSY, o keeps its previous value.
- in_valid while in_ready=0: no effect. The issuer must hold its request until it is accepted.
- rst_n asserted in any state, including mid-MUL: immediate return to reset values; no partial result is ever presented.

Test Plan:
- W=4, a=7, b=3, ops 0..9 and 11..13 issued back-to-back with out_ready=1. Required: one result per cycle, first at 1-cycle latency. ADD: o=0xA, neg=1, ovf=1, carry=0. SUB: o=4, carry=0. SHL: o=0xE. DEC: o=6.
- W=4: a=2, b=3 SUB -> o=0xF, carry=1, neg=1. a=5, b=5 EQ -> o=1. a=2, b=3 LT -> o=1. a=0xF INC -> o=0, zero=1, carry=1.
- W=4, MUL a=7, b=3. Required: in_ready=0 for 4 cycles; out_valid on the 5th edge after accept; o=5 (21 mod 16), carry=1. Then MUL a=3, b=5 -> o=0xF, carry=0.
- Backpressure: hold out_ready=0 for 6 cycles after an ADD result. Required: o and flags stable, in_ready=0, a new in_valid is not accepted. Releasing out_ready with in_valid high accepts the next op on that edge.
- Reset mid-MUL: assert rst_n=0 at BUSY cycle 2. Required: out_valid=0, o=0 and all flags 0 immediately (async). After release, in_ready=1 and the next ADD 1+1 -> o=2.
- W=8 instance: MUL a=0x10, b=0x10 -> o=0x00, zero=1, carry=1, latency 9 edges. ADD 0x7F+0x01 -> o=0x80, ovf=1, neg=1.
